// File: rtl/des12_pkg.sv
// Shared constants and helpers for the des12 12-bit serial-to-parallel deserializer.
package des12_pkg;

  localparam int FRAME_W  = 12;
  localparam int CNT_W    = 4;
  localparam int LAST_IDX = 11;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  // Final frame position of the bit received when the counter reads cnt.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] cnt, input bit msb_first);
    logic [CNT_W-1:0] pos;
    if (msb_first == ORDER_MSB_FIRST) begin
      pos = CNT_W'(LAST_IDX) - cnt;
    end else begin
      pos = cnt;
    end
    return pos;
  endfunction

endpackage

// File: rtl/cnt_mod12.sv
// Modulo-12 bit counter with enable, synchronous clear and asynchronous clear.
module cnt_mod12
  import des12_pkg::*;
(
  input  logic             CK,
  input  logic             CD,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == CNT_W'(LAST_IDX));
  assign cnt_o = cnt_q;

  // Clear wins over enable; the only wrap back to zero is from the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (tc_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/des12.sv
// 12-bit serial-to-parallel deserializer: shift register, holding register and
// valid/ready handshake on twelve registered single-bit outputs.
module des12
  import des12_pkg::*;
#(
  parameter bit MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic CK,
  input  logic CD,
  input  logic SI,
  input  logic SV,
  input  logic SCLR,
  input  logic RD,
  output logic Z0,
  output logic Z1,
  output logic Z2,
  output logic Z3,
  output logic Z4,
  output logic Z5,
  output logic Z6,
  output logic Z7,
  output logic Z8,
  output logic Z9,
  output logic Z10,
  output logic Z11,
  output logic ZV,
  output logic SR
);

  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [FRAME_W-1:0] z_q, z_d;
  logic [FRAME_W-1:0] frame_s;
  logic               zv_q, zv_d;
  logic [CNT_W-1:0]   cnt_s;
  logic               tc_s;
  logic               accept_s, take_s, complete_s, consume_s;

  // Only the last bit of a frame can be refused: it needs a free holding register.
  assign SR         = !(tc_s && zv_q && !RD);
  assign accept_s   = SV && SR;
  assign take_s     = accept_s && !SCLR;
  assign complete_s = take_s && tc_s;
  assign consume_s  = zv_q && RD;

  cnt_mod12 u_cnt (
    .CK    (CK),
    .CD    (CD),
    .en_i  (take_s),
    .clr_i (SCLR),
    .cnt_o (cnt_s),
    .tc_o  (tc_s)
  );

  always_comb begin
    frame_s = sh_q;
    frame_s[bit_pos(cnt_s, MSB_FIRST)] = SI;

    if (SCLR || complete_s) begin
      sh_d = '0;
    end else if (take_s) begin
      sh_d = frame_s;
    end else begin
      sh_d = sh_q;
    end

    z_d = complete_s ? frame_s : z_q;

    // A completing frame keeps ZV high even when the old one is consumed.
    if (complete_s) begin
      zv_d = 1'b1;
    end else if (consume_s) begin
      zv_d = 1'b0;
    end else begin
      zv_d = zv_q;
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      sh_q <= '0;
      z_q  <= '0;
      zv_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      z_q  <= z_d;
      zv_q <= zv_d;
    end
  end

  assign {Z11, Z10, Z9, Z8, Z7, Z6, Z5, Z4, Z3, Z2, Z1, Z0} = z_q;
  assign ZV = zv_q;

endmodule

// File: tb/tb_des12.sv
// Scoreboard bench for des12: both bit orders run side by side on shared stimulus.
module tb_des12;

  logic CK = 1'b0;
  logic CD = 1'b1;
  logic SI = 1'b0;
  logic SV = 1'b0;
  logic SCLR = 1'b0;
  logic RD = 1'b0;

  wire [11:0] za, zb;
  wire        zva, zvb, sra, srb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sr_drops = 0;
  bit b2b = 1'b0;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  int pop_cyc[$];
  logic [11:0] ea, eb;

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  des12 #(.MSB_FIRST(1'b0)) dut_lsb (
    .CK(CK), .CD(CD), .SI(SI), .SV(SV), .SCLR(SCLR), .RD(RD),
    .Z0(za[0]), .Z1(za[1]), .Z2(za[2]), .Z3(za[3]), .Z4(za[4]), .Z5(za[5]),
    .Z6(za[6]), .Z7(za[7]), .Z8(za[8]), .Z9(za[9]), .Z10(za[10]), .Z11(za[11]),
    .ZV(zva), .SR(sra)
  );

  des12 #(.MSB_FIRST(1'b1)) dut_msb (
    .CK(CK), .CD(CD), .SI(SI), .SV(SV), .SCLR(SCLR), .RD(RD),
    .Z0(zb[0]), .Z1(zb[1]), .Z2(zb[2]), .Z3(zb[3]), .Z4(zb[4]), .Z5(zb[5]),
    .Z6(zb[6]), .Z7(zb[7]), .Z8(zb[8]), .Z9(zb[9]), .Z10(zb[10]), .Z11(zb[11]),
    .ZV(zvb), .SR(srb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every consumed frame is compared against the scoreboard.
  always @(negedge CK) begin
    if (b2b && !(sra && srb)) sr_drops++;
    if (!CD && zva && RD) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", za);
      end else begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("frame_lsb", {20'd0, za}, {20'd0, ea});
        check("frame_msb", {20'd0, zb}, {20'd0, eb});
        check("zv_msb", {31'd0, zvb}, 32'd1);
        if (b2b) pop_cyc.push_back(cyc);
      end
    end
  end

  // Present one bit and hold it until an edge where SR lets it in.
  task automatic send_bit(input logic b);
    int t;
    SI = b;
    SV = 1'b1;
    t = 0;
    @(negedge CK);
    while (!(sra && srb) && t < 200) begin
      @(negedge CK);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: got SR=0 expected SR=1 within 200 cycles");
    end
    @(posedge CK);
    #1;
  endtask

  task automatic send_frame(input logic [11:0] f, input logic [11:0] xa,
                            input logic [11:0] xb, input bit push);
    for (int k = 0; k < 12; k++) begin
      if (k == 11 && push) begin
        q_a.push_back(xa);
        q_b.push_back(xb);
      end
      send_bit(f[k]);
    end
  endtask

  task automatic idle(input int n);
    SV = 1'b0;
    repeat (n) @(posedge CK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CK);
    #1;
    check("reset_z", {20'd0, za}, 32'd0);
    check("reset_zv", {31'd0, zva}, 32'd0);
    check("reset_sr", {30'd0, sra, srb}, 32'd3);
    CD = 1'b0;

    // Reset mid-frame: hold an all-ones frame, start a new one, then clear.
    RD = 1'b0;
    send_frame(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    SV = 1'b0;
    CD = 1'b1;
    #1;
    check("cd_z_lsb", {20'd0, za}, 32'd0);
    check("cd_z_msb", {20'd0, zb}, 32'd0);
    check("cd_zv", {30'd0, zva, zvb}, 32'd0);
    check("cd_sr_during", {30'd0, sra, srb}, 32'd3);
    @(posedge CK);
    #1;
    CD = 1'b0;
    #1;
    check("cd_sr_after", {30'd0, sra, srb}, 32'd3);
    RD = 1'b1;
    send_frame(12'h3C7, 12'h3C7, 12'hE3C, 1'b1);
    idle(3);

    // Bit order and latency.
    send_frame(12'h801, 12'h801, 12'h801, 1'b1);
    check("zv_latency", {31'd0, zva}, 32'd1);
    send_frame(12'h001, 12'h001, 12'h800, 1'b1);
    send_frame(12'hA5C, 12'hA5C, 12'h3A5, 1'b1);
    idle(3);

    // All-ones frame drives a 12-input AND high while valid.
    check("and12_before", {31'd0, &za}, 32'd0);
    send_frame(12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
    check("and12_valid", {30'd0, &za, zva}, 32'd3);
    idle(3);

    // Back-to-back: three frames, 36 bits, no SR drops.
    b2b = 1'b1;
    send_frame(12'h123, 12'h123, 12'hC48, 1'b1);
    send_frame(12'hFF0, 12'hFF0, 12'h0FF, 1'b1);
    send_frame(12'h555, 12'h555, 12'hAAA, 1'b1);
    idle(3);
    b2b = 1'b0;
    check("b2b_pulses", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 32'd12);
      check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 32'd12);
    end
    check("b2b_sr_drops", sr_drops, 32'd0);

    // Backpressure: frame A held, last bit of frame B refused until RD rises.
    RD = 1'b0;
    send_frame(12'h00F, 12'h00F, 12'hF00, 1'b1);
    for (int k = 0; k < 11; k++) send_bit(k == 0 || k == 6 || k == 7);
    check("bp_sr_low", {30'd0, sra, srb}, 32'd0);
    SI = 1'b1;
    SV = 1'b1;
    repeat (3) begin
      @(negedge CK);
      check("bp_hold_sr", {31'd0, sra}, 32'd0);
      check("bp_hold_z", {19'd0, zva, za}, {19'd0, 1'b1, 12'h00F});
    end
    @(posedge CK);
    #1;
    q_a.push_back(12'h8C1);
    q_b.push_back(12'h831);
    RD = 1'b1;
    @(posedge CK);
    #1;
    SV = 1'b0;
    check("bp_no_bubble", {19'd0, zva, za}, {19'd0, 1'b1, 12'h8C1});
    idle(3);

    // SCLR drops the partial frame and the bit presented with it.
    for (int k = 0; k < 7; k++) send_bit(1'b1);
    SCLR = 1'b1;
    SI = 1'b1;
    SV = 1'b1;
    @(posedge CK);
    #1;
    SCLR = 1'b0;
    SV = 1'b0;
    check("sclr_keeps_z", {19'd0, zva, za}, {19'd0, 1'b0, 12'h8C1});
    send_frame(12'h6B2, 12'h6B2, 12'h4D6, 1'b1);
    idle(3);

    check("scoreboard_empty", q_a.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
